prio_encoder_pipe: RTL and testbench
====================================

// Module: prio_encoder_pipe
// PURPOSE
//   Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides.
//   Selectable fixed-LSB, fixed-MSB or round-robin priority.
//   Flags zero and multi-hot inputs instead of producing X; keeps a saturating error count.
//   Sits between request/interrupt vectors and downstream index consumers (arbiters, mux selects).
// PARAMETERS
//   N      8              number of request lines, 2..256
//   W      $clog2(N)      index width, derived; do not override
//   MODE   0              0 = fixed LSB-first, 1 = fixed MSB-first, 2 = round-robin
//   ECW    8              width of the error counter
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    req is valid this cycle
//   in_ready   out  1    block can accept req this cycle
//   req        in   N    request vector
//   out_valid  out  1    out_* fields valid
//   out_ready  in   1    downstream accepts out_* this cycle
//   out_idx    out  W    encoded index of the granted bit
//   out_none   out  1    accepted req was all-zero
//   out_multi  out  1    accepted req had more than one bit set
//   err_cnt    out  ECW  saturating count of accepted non-one-hot vectors
// BEHAVIOUR
//   Reset (async assert, sync deassert by the system)
//     out_valid=0, out_idx=0, out_none=0, out_multi=0, err_cnt=0, rr pointer=0.
//   Handshake
//     - in_ready = !out_valid || out_ready (combinational; single output register, no skid).
//     - Accept when in_valid && in_ready. Latency 1: out_* update on the next clk edge.
//     - Hold: out_valid=1 && out_ready=0 -> out_* and err_cnt stable; in_ready=0.
//     - Drain: out_valid=1 && out_ready=1 && !in_valid -> out_valid falls to 0 next cycle.
//       out_idx, out_none and out_multi keep their last values.
//     - Back-to-back: out_ready=1 and in_valid=1 every cycle -> one result per cycle.
//   Encoding
//     - MODE0: out_idx = lowest set bit.
//     - MODE1: out_idx = highest set bit.
//     - MODE2: out_idx = first set bit at or above ptr, searching upward and wrapping N-1 -> 0.
//       - On each accepted nonzero req: ptr <= (out_idx == N-1) ? 0 : out_idx+1.
//       - Wrap is mod N, correct for non-power-of-2 N.
//       - ptr is unchanged on zero req or when no transfer occurs.
//     - req == 0: out_none=1, out_idx=0, out_multi=0.
//     - popcount(req) >= 2: out_multi=1, out_idx per MODE.
//   Error counter
//     - +1 on each accepted transfer where popcount(req) != 1 (zero or multi-hot).
//     - Saturates at 2^ECW-1; never wraps.
//   Inputs
//     - req and in_valid are sampled only on accept.
//     - X on req while in_valid=0 must not propagate to the outputs.
// STRUCTURE
//   Shared package: MODE_LSB/MODE_MSB/MODE_RR localparams, used by instantiators.
//   One sub-module: prio_find (combinational; inputs req, start; outputs idx, found).
//     - MODE0: start=0.
//     - MODE1: bit-reversed req.
//     - MODE2: start=ptr, implemented as a double-width rotate-and-search.
//   Top holds the output register, ptr register, err_cnt and popcount-ge-2 detect.
// TESTING
//   1. N=8 MODE0, walk one-hot 8'h01..8'h80, out_ready=1
//      -> idx 0..7 one cycle after each accept; none=multi=0; err_cnt=0.
//   2. N=8 MODE0/MODE1, req=8'b0010_0100
//      -> idx=2 / idx=5; out_multi=1; err_cnt increments by 1 each.
//   3. req=0 accepted -> out_none=1, out_idx=0, err_cnt+1; never X.
//   4. MODE2 N=5, req=5'b11111 held for 7 transfers
//      -> idx 0,1,2,3,4,0,1 (wrap at N-1).
//   5. out_ready=0 for 4 cycles with in_valid=1
//      -> in_ready=0; outputs and ptr frozen; the next value is accepted on the cycle
//         after out_ready rises.
//   6. ECW=2, 5 multi-hot transfers -> err_cnt 1,2,3,3,3.
//      rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/prio_encoder_pipe_pkg.sv
// Shared priority-mode selectors for prio_encoder_pipe instantiators.
// No logic: constants only.
// No flow control involved.
package prio_encoder_pipe_pkg;

    localparam int MODE_LSB = 0;   // lowest set bit wins
    localparam int MODE_MSB = 1;   // highest set bit wins
    localparam int MODE_RR  = 2;   // round-robin, search starts at rotating pointer

endpackage

// File: rtl/prio_encoder_pipe_find.sv
// Finds the first set bit of req at or above start, wrapping N-1 -> 0.
// Latency 0: purely combinational.
// No flow control; the caller decides when the result is used.
module prio_find #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    localparam logic [W:0] LP_N = (W+1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_off;
    logic [W:0]     w_sum;

    // Two copies side by side make the wrap a plain shift: bit k of w_rot is req[(start+k) mod N]
    assign w_dbl = {req, req};
    assign w_rot = N'(w_dbl >> start);

    // Lowest set bit of the rotated vector is the distance from start to the winner
    always_comb begin
        w_off = '0;
        found = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = W'(i);
                found = 1'b1;
            end
        end
    end

    // Undo the rotation with an explicit mod-N so non-power-of-2 N wraps correctly
    assign w_sum = {1'b0, start} + {1'b0, w_off};
    assign idx   = (w_sum >= LP_N) ? W'(w_sum - LP_N) : w_sum[W-1:0];

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with zero/multi-hot flags and saturating error count.
// Latency 1: result appears the clock after accept.
// Single output register: in_ready = !out_valid || out_ready, no skid buffer.
module prio_encoder_pipe
    import prio_encoder_pipe_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = MODE_LSB,
    parameter int ECW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   req,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_idx,
    output logic           out_none,
    output logic           out_multi,
    output logic [ECW-1:0] err_cnt
);

    logic           w_accept;
    logic [N-1:0]   w_find_req;
    logic [W-1:0]   w_start;
    logic [W-1:0]   w_find_idx;
    logic           w_found;
    logic [W-1:0]   w_idx;
    logic           w_multi;

    logic           r_out_valid;
    logic [W-1:0]   r_out_idx;
    logic           r_out_none;
    logic           r_out_multi;
    logic [W-1:0]   r_ptr;
    logic [ECW-1:0] r_err_cnt;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // MSB-first reuses the LSB-first search on a mirrored vector
    always_comb begin
        w_find_req = req;
        if (MODE == MODE_MSB) begin
            for (int i = 0; i < N; i++) begin
                w_find_req[i] = req[N-1-i];
            end
        end
    end

    assign w_start = (MODE == MODE_RR) ? r_ptr : '0;

    prio_find #(
        .N (N),
        .W (W)
    ) u_find (
        .req   (w_find_req),
        .start (w_start),
        .idx   (w_find_idx),
        .found (w_found)
    );

    // Map the search result back to a req bit position; all-zero input reports index 0
    always_comb begin
        w_idx = '0;
        if (w_found) begin
            if (MODE == MODE_MSB) w_idx = W'(N-1) - w_find_idx;
            else                  w_idx = w_find_idx;
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set
    assign w_multi = |(req & (req - N'(1)));

    // Output register: load on accept, drop valid on drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_none  <= 1'b0;
            r_out_multi <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_idx;
            r_out_none  <= !w_found;
            r_out_multi <= w_multi;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner; zero vectors leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (MODE == MODE_RR && w_accept && w_found) begin
            r_ptr <= (w_idx == W'(N-1)) ? '0 : w_idx + W'(1);
        end
    end

    // Count accepted vectors that are not one-hot, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && (!w_found || w_multi) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ECW'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_none  = r_out_none;
    assign out_multi = r_out_multi;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
module tb_prio_encoder_pipe;
    import prio_encoder_pipe_pkg::*;

    typedef struct packed {
        logic [2:0] idx;
        logic       none;
        logic       multi;
        logic [7:0] err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       out_ready;
    logic [7:0] req;
    logic       a_iv, b_iv, c_iv, d_iv;

    logic       a_ir, a_ov, a_none, a_multi;
    logic [2:0] a_idx;
    logic [7:0] a_err;
    logic       b_ir, b_ov, b_none, b_multi;
    logic [2:0] b_idx;
    logic [7:0] b_err;
    logic       c_ir, c_ov, c_none, c_multi;
    logic [2:0] c_idx;
    logic [7:0] c_err;
    logic       d_ir, d_ov, d_none, d_multi;
    logic [2:0] d_idx;
    logic [1:0] d_err;

    exp_t qa[$], qb[$], qc[$], qd[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    prio_encoder_pipe #(.N(8), .MODE(MODE_LSB), .ECW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .req(req),
        .out_valid(a_ov), .out_ready(out_ready), .out_idx(a_idx), .out_none(a_none),
        .out_multi(a_multi), .err_cnt(a_err));

    prio_encoder_pipe #(.N(8), .MODE(MODE_MSB), .ECW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .req(req),
        .out_valid(b_ov), .out_ready(out_ready), .out_idx(b_idx), .out_none(b_none),
        .out_multi(b_multi), .err_cnt(b_err));

    prio_encoder_pipe #(.N(5), .MODE(MODE_RR), .ECW(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .req(req[4:0]),
        .out_valid(c_ov), .out_ready(out_ready), .out_idx(c_idx), .out_none(c_none),
        .out_multi(c_multi), .err_cnt(c_err));

    prio_encoder_pipe #(.N(8), .MODE(MODE_LSB), .ECW(2)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .req(req),
        .out_valid(d_ov), .out_ready(out_ready), .out_idx(d_idx), .out_none(d_none),
        .out_multi(d_multi), .err_cnt(d_err));

    function automatic exp_t mk(input logic [2:0] idx, input logic none,
                                input logic multi, input logic [7:0] err);
        exp_t e;
        e.idx = idx; e.none = none; e.multi = multi; e.err = err;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string name, input exp_t act, input exp_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d none=%0b multi=%0b err=%0d, expected idx=%0d none=%0b multi=%0b err=%0d",
                     name, act.idx, act.none, act.multi, act.err,
                     exp.idx, exp.none, exp.multi, exp.err);
        end
    endtask

    task automatic pop_cmp(input string name, input int q, input exp_t act);
        exp_t e;
        int   sz;
        case (q)
            0:       sz = qa.size();
            1:       sz = qb.size();
            2:       sz = qc.size();
            default: sz = qd.size();
        endcase
        if (sz == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_unexpected: got output idx=%0d with empty scoreboard, expected none", name, act.idx);
        end else begin
            case (q)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                2:       e = qc.pop_front();
                default: e = qd.pop_front();
            endcase
            cmp_out(name, act, e);
        end
    endtask

    // Monitors: a transfer happens at the next rising edge when valid and ready are both high
    always @(negedge clk) if (rst_n && a_ov && out_ready) pop_cmp("a_out", 0, mk(a_idx, a_none, a_multi, a_err));
    always @(negedge clk) if (rst_n && b_ov && out_ready) pop_cmp("b_out", 1, mk(b_idx, b_none, b_multi, b_err));
    always @(negedge clk) if (rst_n && c_ov && out_ready) pop_cmp("c_out", 2, mk(c_idx, c_none, c_multi, c_err));
    always @(negedge clk) if (rst_n && d_ov && out_ready) pop_cmp("d_out", 3, mk(d_idx, d_none, d_multi, {6'b0, d_err}));

    function automatic logic rdy(input int d);
        case (d)
            0:       return a_ir;
            1:       return b_ir;
            2:       return c_ir;
            default: return d_ir;
        endcase
    endfunction

    task automatic set_iv(input int d, input logic v);
        case (d)
            0:       a_iv = v;
            1:       b_iv = v;
            2:       c_iv = v;
            default: d_iv = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one vector to one DUT, record its expected result, wait (bounded) for acceptance
    task automatic send(input int d, input logic [7:0] r, input exp_t e);
        logic acc;
        int   waited;
        acc    = 1'b0;
        waited = 0;
        case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            2:       qc.push_back(e);
            default: qd.push_back(e);
        endcase
        req = r;
        set_iv(d, 1'b1);
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = rdy(d);
            @(posedge clk);
            #1;
            waited++;
        end
        set_iv(d, 1'b0);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: dut %0d in_ready stayed 0, expected 1 within 50 cycles", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; out_ready = 1'b1; req = 8'h00;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0;

        #2;
        check("reset_a", 32'({a_ov, a_idx, a_none, a_multi, a_err}), 32'd0);
        check("reset_c", 32'({c_ov, c_idx, c_none, c_multi, c_err}), 32'd0);
        check("reset_d", 32'({d_ov, d_idx, d_none, d_multi, d_err}), 32'd0);
        check("reset_a_in_ready", 32'(a_ir), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Walking one-hot, back-to-back on LSB-first
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            send(0, v, mk(3'(i), 1'b0, 1'b0, 8'd0));
        end
        idle(3);

        // Multi-hot on both fixed priorities, plus MSB-first edge positions
        send(0, 8'h24, mk(3'd2, 1'b0, 1'b1, 8'd1));
        send(1, 8'h24, mk(3'd5, 1'b0, 1'b1, 8'd1));
        send(1, 8'h81, mk(3'd7, 1'b0, 1'b1, 8'd2));
        send(1, 8'h10, mk(3'd4, 1'b0, 1'b0, 8'd2));
        send(1, 8'h01, mk(3'd0, 1'b0, 1'b0, 8'd2));
        idle(3);

        // All-zero vector, then X on req while idle must not reach the outputs
        send(0, 8'h00, mk(3'd0, 1'b1, 1'b0, 8'd2));
        idle(2);
        req = 8'hxx;
        idle(3);
        check("a_no_x", 32'($isunknown({a_ov, a_idx, a_none, a_multi, a_err})), 32'd0);
        check("a_drain_hold", 32'({a_ov, a_idx, a_none}), 32'({1'b0, 3'd0, 1'b1}));
        req = 8'h00;

        // Round-robin N=5: wrap at N-1 and mod-5 pointer behaviour
        send(2, 8'h1F, mk(3'd0, 1'b0, 1'b1, 8'd1));
        send(2, 8'h1F, mk(3'd1, 1'b0, 1'b1, 8'd2));
        send(2, 8'h1F, mk(3'd2, 1'b0, 1'b1, 8'd3));
        send(2, 8'h1F, mk(3'd3, 1'b0, 1'b1, 8'd4));
        send(2, 8'h1F, mk(3'd4, 1'b0, 1'b1, 8'd5));
        send(2, 8'h1F, mk(3'd0, 1'b0, 1'b1, 8'd6));
        send(2, 8'h1F, mk(3'd1, 1'b0, 1'b1, 8'd7));
        send(2, 8'h01, mk(3'd0, 1'b0, 1'b0, 8'd7));
        send(2, 8'h12, mk(3'd1, 1'b0, 1'b1, 8'd8));
        send(2, 8'h00, mk(3'd0, 1'b1, 1'b0, 8'd9));
        send(2, 8'h11, mk(3'd4, 1'b0, 1'b1, 8'd10));
        idle(3);

        // Backpressure: four stalled cycles, outputs and pointer frozen
        out_ready = 1'b0;
        send(2, 8'h1F, mk(3'd0, 1'b0, 1'b1, 8'd11));
        qc.push_back(mk(3'd1, 1'b0, 1'b1, 8'd12));
        req  = 8'h1F;
        c_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("c_hold_in_ready", 32'(c_ir), 32'd0);
            check("c_hold_out", 32'({c_ov, c_idx, c_err}), 32'({1'b1, 3'd0, 8'd11}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("c_release_in_ready", 32'(c_ir), 32'd1);
        @(posedge clk);
        #1 c_iv = 1'b0;
        idle(3);
        check("c_drain", 32'({c_ov, c_idx}), 32'({1'b0, 3'd1}));

        // Narrow error counter saturates
        send(3, 8'h03, mk(3'd0, 1'b0, 1'b1, 8'd1));
        send(3, 8'h0C, mk(3'd2, 1'b0, 1'b1, 8'd2));
        send(3, 8'h30, mk(3'd4, 1'b0, 1'b1, 8'd3));
        send(3, 8'hC0, mk(3'd6, 1'b0, 1'b1, 8'd3));
        send(3, 8'hFF, mk(3'd0, 1'b0, 1'b1, 8'd3));
        idle(3);

        // Asynchronous reset while results are held
        out_ready = 1'b0;
        send(3, 8'h01, mk(3'd0, 1'b0, 1'b0, 8'd3));
        send(2, 8'h1F, mk(3'd2, 1'b0, 1'b1, 8'd13));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", 32'({a_ov, a_idx, a_none, a_multi, a_err}), 32'd0);
        check("async_reset_c", 32'({c_ov, c_idx, c_none, c_multi, c_err}), 32'd0);
        check("async_reset_d", 32'({d_ov, d_idx, d_none, d_multi, d_err}), 32'd0);
        qc.delete();
        qd.delete();
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send(2, 8'h1F, mk(3'd0, 1'b0, 1'b1, 8'd1));
        send(3, 8'h03, mk(3'd0, 1'b0, 1'b1, 8'd1));
        idle(4);

        check("qa_empty", 32'(qa.size()), 32'd0);
        check("qb_empty", 32'(qb.size()), 32'd0);
        check("qc_empty", 32'(qc.size()), 32'd0);
        check("qd_empty", 32'(qd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
